bp_cacc_vdp_stream: RTL and testbench

Parametrised streaming vector accelerator, the next generation of the CACC vector dot-product unit. Accepts vectors longer than its lane count by fetching them in chunks of lanes_p elements and accumulating across chunks. Supports signed dot product and L1 distance. Sits behind the CACC CSR (uncached I/O) port and issues single-element loads and one result store on a generic in-order memory port.

---
 rtl/bp_cacc_pkg.sv | 49 ++++
 rtl/bp_cacc_vdp_lanes.sv | 47 ++++
 rtl/bp_cacc_vdp_stream.sv | 323 ++++++++++++++++++++++++++++++++
 tb/tb_bp_cacc_vdp_stream.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_cacc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_cacc_pkg
// Description : Shared constants and types for the CACC streaming vector
//               dot-product / L1-distance unit: CSR byte offsets, operation
//               encoding, FSM state encoding and status bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_cacc_pkg;

    // CSR byte offsets (64-bit registers)
    localparam logic [7:0] c_csr_a_ptr   = 8'h00;
    localparam logic [7:0] c_csr_b_ptr   = 8'h08;
    localparam logic [7:0] c_csr_len     = 8'h10;
    localparam logic [7:0] c_csr_start   = 8'h18;
    localparam logic [7:0] c_csr_status  = 8'h20;
    localparam logic [7:0] c_csr_res_ptr = 8'h28;
    localparam logic [7:0] c_csr_op      = 8'h30;
    localparam logic [7:0] c_csr_result  = 8'h38;
    localparam logic [7:0] c_csr_irq_en  = 8'h40;

    // Status register bit positions
    localparam int c_status_done_bit = 0;
    localparam int c_status_err_bit  = 1;

    // Reduction operation selected by the op CSR
    typedef enum logic [0:0] {
        e_cacc_op_dot = 1'b0,
        e_cacc_op_l1  = 1'b1
    } bp_cacc_op_e;

    // Controller states
    localparam logic [2:0] c_st_idle       = 3'd0;
    localparam logic [2:0] c_st_req_a      = 3'd1;
    localparam logic [2:0] c_st_req_b      = 3'd2;
    localparam logic [2:0] c_st_drain      = 3'd3;
    localparam logic [2:0] c_st_accum      = 3'd4;
    localparam logic [2:0] c_st_store      = 3'd5;
    localparam logic [2:0] c_st_store_wait = 3'd6;

    // Sign-extend the low 'width' bits of raw to 64 bits
    function automatic logic [63:0] bp_cacc_sext(input logic [63:0] raw, input int width);
        logic [63:0] w_shl;
        w_shl = raw << (64 - width);
        return $signed(w_shl) >>> (64 - width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bp_cacc_vdp_lanes.sv
`default_nettype none
// ============================================================================
// Module      : bp_cacc_vdp_lanes
// Description : Combinational lane datapath. Each lane forms a*b (dot) or
//               |a-b| (L1) on 64-bit sign-extended operands; a balanced
//               binary adder tree reduces the lanes to one 64-bit sum.
//               All arithmetic wraps modulo 2^64.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_cacc_vdp_lanes
    import bp_cacc_pkg::*;
#(
    parameter int lanes_p = 8
) (
    input  logic [lanes_p-1:0][63:0] i_a,
    input  logic [lanes_p-1:0][63:0] i_b,
    input  logic                     i_op,
    output logic [63:0]              o_sum
);

    localparam int c_nodes = 2 * lanes_p - 1;

    // Heap-ordered tree: node n has children 2n+1 and 2n+2; leaves occupy
    // the upper lanes_p slots, the root is node 0.
    logic [c_nodes-1:0][63:0] w_tree;

    genvar gi;
    generate
        for (gi = 0; gi < lanes_p; gi++) begin : g_lane
            logic [63:0] w_prod;
            logic [63:0] w_diff;
            logic [63:0] w_abs;
            assign w_prod = i_a[gi] * i_b[gi];
            assign w_diff = i_a[gi] - i_b[gi];
            assign w_abs  = w_diff[63] ? (64'd0 - w_diff) : w_diff;
            assign w_tree[lanes_p-1+gi] = (i_op == e_cacc_op_l1) ? w_abs : w_prod;
        end

        for (gi = 0; gi < lanes_p - 1; gi++) begin : g_node
            assign w_tree[gi] = w_tree[2*gi+1] + w_tree[2*gi+2];
        end
    endgenerate

    assign o_sum = w_tree[0];

endmodule
`default_nettype wire

// File: rtl/bp_cacc_vdp_stream.sv
`default_nettype none
// ============================================================================
// Module      : bp_cacc_vdp_stream
// Description : Streaming vector dot-product / L1-distance accelerator.
//               Fetches A and B in chunks of lanes_p elements over a generic
//               in-order memory port, accumulates per chunk, then stores the
//               64-bit result to res_ptr and raises status.done. Controlled
//               through a single-outstanding 64-bit CSR port.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_cacc_vdp_stream
    import bp_cacc_pkg::*;
#(
    parameter int elem_width_p     = 32,
    parameter int lanes_p          = 8,
    parameter int max_len_p        = 256,
    parameter int addr_width_p     = 40,
    parameter int csr_addr_width_p = 8
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        csr_v_i,
    input  logic                        csr_w_i,
    input  logic [csr_addr_width_p-1:0] csr_addr_i,
    input  logic [63:0]                 csr_data_i,
    output logic                        csr_ready_o,
    output logic                        csr_resp_v_o,
    output logic [63:0]                 csr_resp_data_o,
    input  logic                        csr_resp_yumi_i,
    output logic                        mem_req_v_o,
    output logic                        mem_req_w_o,
    output logic [addr_width_p-1:0]     mem_req_addr_o,
    output logic [63:0]                 mem_req_data_o,
    input  logic                        mem_req_ready_i,
    input  logic                        mem_resp_v_i,
    input  logic [63:0]                 mem_resp_data_i,
    output logic                        irq_o
);

    localparam int c_stride = elem_width_p / 8;
    localparam int c_cnt_w  = $clog2(max_len_p + 1);
    localparam int c_lane_w = $clog2(lanes_p + 1);
    localparam int c_resp_w = $clog2(2 * lanes_p + 1);
    localparam int c_idx_w  = $clog2(lanes_p);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]                 r_state;
    logic [63:0]                r_a_ptr;
    logic [63:0]                r_b_ptr;
    logic [63:0]                r_len;
    logic [63:0]                r_res_ptr;
    logic                       r_op;
    logic                       r_irq_en;
    logic [1:0]                 r_status;
    logic [63:0]                r_result;
    logic [63:0]                r_acc;
    logic                       r_csr_resp_v;
    logic [63:0]                r_csr_resp_data;
    logic [c_cnt_w-1:0]         r_remaining;
    logic [c_cnt_w-1:0]         r_base;
    logic [c_lane_w-1:0]        r_chunk_n;
    logic [c_lane_w-1:0]        r_req_idx;
    logic [c_resp_w-1:0]        r_resp_cnt;
    logic [lanes_p-1:0][63:0]   r_a_buf;
    logic [lanes_p-1:0][63:0]   r_b_buf;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic                       w_csr_fire;
    logic                       w_csr_wr;
    logic                       w_busy;
    logic                       w_cfg_wr;
    logic                       w_start_req;
    logic                       w_len_bad;
    logic                       w_mem_fire;
    logic                       w_last_req;
    logic                       w_in_fetch;
    logic [c_resp_w-1:0]        w_chunk2;
    logic                       w_resp_take;
    logic                       w_done;
    logic [63:0]                w_elem;
    logic [c_cnt_w-1:0]         w_remaining_next;
    logic [c_lane_w-1:0]        w_first_chunk;
    logic [c_lane_w-1:0]        w_next_chunk;
    logic [c_cnt_w-1:0]         w_elem_idx;
    logic [addr_width_p-1:0]    w_elem_off;
    logic [63:0]                w_fetch_ptr;
    logic [c_resp_w-1:0]        w_b_idx;
    logic [63:0]                w_lane_sum;
    logic [63:0]                w_rd_data;
    logic [1:0]                 w_status_next;

    assign csr_ready_o     = ~r_csr_resp_v;
    assign csr_resp_v_o    = r_csr_resp_v;
    assign csr_resp_data_o = r_csr_resp_data;
    assign irq_o           = r_status[c_status_done_bit] & r_irq_en;

    assign w_csr_fire  = csr_v_i & csr_ready_o;
    assign w_csr_wr    = w_csr_fire & csr_w_i;
    assign w_busy      = (r_state != c_st_idle);
    assign w_cfg_wr    = w_csr_wr & ~w_busy;
    assign w_start_req = w_csr_wr & ~w_busy & csr_data_i[0]
                       & (csr_addr_i == csr_addr_width_p'(c_csr_start));
    assign w_len_bad   = (r_len == 64'd0) | (r_len > 64'(max_len_p));

    assign mem_req_v_o    = (r_state == c_st_req_a) | (r_state == c_st_req_b)
                          | (r_state == c_st_store);
    assign mem_req_w_o    = (r_state == c_st_store);
    assign mem_req_data_o = (r_state == c_st_store) ? r_acc : 64'd0;

    assign w_mem_fire  = mem_req_v_o & mem_req_ready_i;
    assign w_last_req  = (r_req_idx == (r_chunk_n - c_lane_w'(1)));

    assign w_elem_idx  = r_base + c_cnt_w'(r_req_idx);
    assign w_elem_off  = addr_width_p'(w_elem_idx) * addr_width_p'(c_stride);
    assign w_fetch_ptr = (r_state == c_st_req_b) ? r_b_ptr : r_a_ptr;
    assign mem_req_addr_o = (r_state == c_st_store) ? r_res_ptr[addr_width_p-1:0]
                          : (w_fetch_ptr[addr_width_p-1:0] + w_elem_off);

    // Loads of a chunk may return while later requests are still issuing,
    // so responses are captured in every fetch state, not only DRAIN.
    assign w_in_fetch  = (r_state == c_st_req_a) | (r_state == c_st_req_b)
                       | (r_state == c_st_drain);
    assign w_chunk2    = c_resp_w'({r_chunk_n, 1'b0});
    assign w_resp_take = mem_resp_v_i & w_in_fetch & (r_resp_cnt < w_chunk2);
    assign w_done      = (r_state == c_st_store_wait) & mem_resp_v_i;
    assign w_elem      = bp_cacc_sext(mem_resp_data_i, elem_width_p);
    assign w_b_idx     = r_resp_cnt - c_resp_w'(r_chunk_n);

    assign w_remaining_next = r_remaining - c_cnt_w'(r_chunk_n);
    assign w_first_chunk    = (r_len >= 64'(lanes_p)) ? c_lane_w'(lanes_p)
                                                      : r_len[c_lane_w-1:0];
    assign w_next_chunk     = (w_remaining_next >= c_cnt_w'(lanes_p)) ? c_lane_w'(lanes_p)
                                                                      : w_remaining_next[c_lane_w-1:0];

    bp_cacc_vdp_lanes #(
        .lanes_p (lanes_p)
    ) u_lanes (
        .i_a   (r_a_buf),
        .i_b   (r_b_buf),
        .i_op  (r_op),
        .o_sum (w_lane_sum)
    );

    // CSR read data mux; unmapped offsets read as zero
    always_comb begin
        w_rd_data = 64'd0;
        case (csr_addr_i)
            csr_addr_width_p'(c_csr_a_ptr):   w_rd_data = r_a_ptr;
            csr_addr_width_p'(c_csr_b_ptr):   w_rd_data = r_b_ptr;
            csr_addr_width_p'(c_csr_len):     w_rd_data = r_len;
            csr_addr_width_p'(c_csr_start):   w_rd_data = {63'd0, w_busy};
            csr_addr_width_p'(c_csr_status):  w_rd_data = {62'd0, r_status};
            csr_addr_width_p'(c_csr_res_ptr): w_rd_data = r_res_ptr;
            csr_addr_width_p'(c_csr_op):      w_rd_data = {63'd0, r_op};
            csr_addr_width_p'(c_csr_result):  w_rd_data = r_result;
            csr_addr_width_p'(c_csr_irq_en):  w_rd_data = {63'd0, r_irq_en};
            default:                          w_rd_data = 64'd0;
        endcase
    end

    // Status update: W1C first, then completion so a coincident done wins
    always_comb begin
        w_status_next = r_status;
        if (w_csr_wr && (csr_addr_i == csr_addr_width_p'(c_csr_status))) begin
            w_status_next = r_status & ~csr_data_i[1:0];
        end
        if (w_done) begin
            w_status_next[c_status_done_bit] = 1'b1;
        end
        if (w_start_req && w_len_bad) begin
            w_status_next = 2'b11;
        end
    end

    // CSR response: one outstanding command, held until consumed
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_csr_resp_v    <= 1'b0;
            r_csr_resp_data <= 64'd0;
        end else if (w_csr_fire) begin
            r_csr_resp_v    <= 1'b1;
            r_csr_resp_data <= csr_w_i ? 64'd0 : w_rd_data;
        end else if (csr_resp_yumi_i) begin
            r_csr_resp_v    <= 1'b0;
        end
    end

    // Configuration registers; job parameters are frozen while busy
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_a_ptr   <= 64'd0;
            r_b_ptr   <= 64'd0;
            r_len     <= 64'd0;
            r_res_ptr <= 64'd0;
            r_op      <= 1'b0;
            r_irq_en  <= 1'b0;
        end else begin
            if (w_cfg_wr && (csr_addr_i == csr_addr_width_p'(c_csr_a_ptr)))   r_a_ptr   <= csr_data_i;
            if (w_cfg_wr && (csr_addr_i == csr_addr_width_p'(c_csr_b_ptr)))   r_b_ptr   <= csr_data_i;
            if (w_cfg_wr && (csr_addr_i == csr_addr_width_p'(c_csr_len)))     r_len     <= csr_data_i;
            if (w_cfg_wr && (csr_addr_i == csr_addr_width_p'(c_csr_res_ptr))) r_res_ptr <= csr_data_i;
            if (w_cfg_wr && (csr_addr_i == csr_addr_width_p'(c_csr_op)))      r_op      <= csr_data_i[0];
            if (w_csr_wr && (csr_addr_i == csr_addr_width_p'(c_csr_irq_en)))  r_irq_en  <= csr_data_i[0];
        end
    end

    // Status and result registers
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_status <= 2'b00;
            r_result <= 64'd0;
        end else begin
            r_status <= w_status_next;
            if (w_done) begin
                r_result <= r_acc;
            end
        end
    end

    // Control FSM with chunk bookkeeping and the accumulator
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state     <= c_st_idle;
            r_acc       <= 64'd0;
            r_remaining <= '0;
            r_base      <= '0;
            r_chunk_n   <= '0;
            r_req_idx   <= '0;
            r_resp_cnt  <= '0;
        end else begin
            if (w_resp_take) begin
                r_resp_cnt <= r_resp_cnt + c_resp_w'(1);
            end
            case (r_state)
                c_st_idle: begin
                    if (w_start_req && !w_len_bad) begin
                        r_acc       <= 64'd0;
                        r_remaining <= c_cnt_w'(r_len);
                        r_base      <= '0;
                        r_chunk_n   <= w_first_chunk;
                        r_req_idx   <= '0;
                        r_resp_cnt  <= '0;
                        r_state     <= c_st_req_a;
                    end
                end
                c_st_req_a: begin
                    if (w_mem_fire) begin
                        if (w_last_req) begin
                            r_req_idx <= '0;
                            r_state   <= c_st_req_b;
                        end else begin
                            r_req_idx <= r_req_idx + c_lane_w'(1);
                        end
                    end
                end
                c_st_req_b: begin
                    if (w_mem_fire) begin
                        if (w_last_req) begin
                            r_req_idx <= '0;
                            r_state   <= c_st_drain;
                        end else begin
                            r_req_idx <= r_req_idx + c_lane_w'(1);
                        end
                    end
                end
                c_st_drain: begin
                    if (r_resp_cnt == w_chunk2) begin
                        r_state <= c_st_accum;
                    end
                end
                c_st_accum: begin
                    r_acc       <= r_acc + w_lane_sum;
                    r_base      <= r_base + c_cnt_w'(r_chunk_n);
                    r_remaining <= w_remaining_next;
                    r_resp_cnt  <= '0;
                    if (w_remaining_next != '0) begin
                        r_chunk_n <= w_next_chunk;
                        r_state   <= c_st_req_a;
                    end else begin
                        r_state   <= c_st_store;
                    end
                end
                c_st_store: begin
                    if (mem_req_ready_i) begin
                        r_state <= c_st_store_wait;
                    end
                end
                c_st_store_wait: begin
                    if (mem_resp_v_i) begin
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Operand buffers: A fills first, then B; cleared at each chunk start
    // so lanes beyond a partial chunk contribute zero.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_a_buf <= '0;
            r_b_buf <= '0;
        end else if ((r_state == c_st_accum) || (w_start_req && !w_len_bad)) begin
            r_a_buf <= '0;
            r_b_buf <= '0;
        end else if (w_resp_take) begin
            if (r_resp_cnt < c_resp_w'(r_chunk_n)) begin
                r_a_buf[r_resp_cnt[c_idx_w-1:0]] <= w_elem;
            end else begin
                r_b_buf[w_b_idx[c_idx_w-1:0]] <= w_elem;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bp_cacc_vdp_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_bp_cacc_vdp_stream
// Description : Directed self-checking bench for bp_cacc_vdp_stream with a
//               behavioural in-order memory (1-cycle response latency,
//               optional ready stall and response hold).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bp_cacc_vdp_stream;

    localparam int ELEM_W  = 32;
    localparam int LANES   = 8;
    localparam int MAX_LEN = 256;
    localparam int AW      = 40;
    localparam int CAW     = 8;

    logic              clk_i;
    logic              reset_n_i;
    logic              csr_v_i;
    logic              csr_w_i;
    logic [CAW-1:0]    csr_addr_i;
    logic [63:0]       csr_data_i;
    logic              csr_ready_o;
    logic              csr_resp_v_o;
    logic [63:0]       csr_resp_data_o;
    logic              csr_resp_yumi_i;
    logic              mem_req_v_o;
    logic              mem_req_w_o;
    logic [AW-1:0]     mem_req_addr_o;
    logic [63:0]       mem_req_data_o;
    logic              mem_req_ready_i;
    logic              mem_resp_v_i;
    logic [63:0]       mem_resp_data_i;
    logic              irq_o;

    bp_cacc_vdp_stream #(
        .elem_width_p     (ELEM_W),
        .lanes_p          (LANES),
        .max_len_p        (MAX_LEN),
        .addr_width_p     (AW),
        .csr_addr_width_p (CAW)
    ) dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .csr_v_i         (csr_v_i),
        .csr_w_i         (csr_w_i),
        .csr_addr_i      (csr_addr_i),
        .csr_data_i      (csr_data_i),
        .csr_ready_o     (csr_ready_o),
        .csr_resp_v_o    (csr_resp_v_o),
        .csr_resp_data_o (csr_resp_data_o),
        .csr_resp_yumi_i (csr_resp_yumi_i),
        .mem_req_v_o     (mem_req_v_o),
        .mem_req_w_o     (mem_req_w_o),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_req_data_o  (mem_req_data_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_resp_v_i    (mem_resp_v_i),
        .mem_resp_data_i (mem_resp_data_i),
        .irq_o           (irq_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Memory model
    // ------------------------------------------------------------------
    logic [63:0]   mem_m [logic [AW-1:0]];
    logic [63:0]   resp_q [$];
    int            ld_count     = 0;
    int            st_count     = 0;
    int            req_v_cycles = 0;
    logic [AW-1:0] st_addr      = '0;
    logic [63:0]   st_data      = '0;
    bit            resp_hold    = 1'b0;
    int            stall_at     = -1;
    int            stall_left   = 0;
    int            stall_bad    = 0;
    bit            stall_seen   = 1'b0;
    logic [AW-1:0] stall_addr   = '0;

    initial begin
        mem_req_ready_i = 1'b1;
        mem_resp_v_i    = 1'b0;
        mem_resp_data_i = 64'd0;
        forever begin
            @(negedge clk_i);
            if (!resp_hold && resp_q.size() > 0) begin
                mem_resp_v_i    = 1'b1;
                mem_resp_data_i = resp_q.pop_front();
            end else begin
                mem_resp_v_i    = 1'b0;
                mem_resp_data_i = 64'd0;
            end
            if (stall_left > 0 && ld_count == stall_at) begin
                mem_req_ready_i = 1'b0;
                if (!stall_seen) begin
                    stall_seen = 1'b1;
                    stall_addr = mem_req_addr_o;
                end
                if (!mem_req_v_o || mem_req_w_o || mem_req_addr_o !== stall_addr) stall_bad++;
                stall_left--;
            end else begin
                mem_req_ready_i = 1'b1;
            end
            if (mem_req_v_o) req_v_cycles++;
            if (mem_req_v_o && mem_req_ready_i) begin
                if (mem_req_w_o) begin
                    st_count++;
                    st_addr = mem_req_addr_o;
                    st_data = mem_req_data_o;
                    resp_q.push_back(64'd0);
                end else begin
                    ld_count++;
                    resp_q.push_back(mem_m.exists(mem_req_addr_o) ? mem_m[mem_req_addr_o]
                                                                  : 64'hBAD0_BAD0_BAD0_BAD0);
                end
            end
        end
    end

    // Upper 32 bits hold junk the DUT must ignore for 32-bit elements
    task automatic set_elem(input logic [AW-1:0] base, input int idx, input logic [31:0] val);
        mem_m[base + AW'(idx * 4)] = {32'hA5A5_5A5A, val};
    endtask

    task automatic clear_stats();
        ld_count     = 0;
        st_count     = 0;
        req_v_cycles = 0;
        st_addr      = '0;
        st_data      = '0;
    endtask

    // ------------------------------------------------------------------
    // CSR access
    // ------------------------------------------------------------------
    task automatic csr_op(input bit w, input logic [7:0] addr, input logic [63:0] data,
                          output logic [63:0] rdata);
        int t;
        t = 0;
        @(negedge clk_i);
        while (!csr_ready_o && t < 50) begin
            @(negedge clk_i);
            t++;
        end
        csr_v_i    = 1'b1;
        csr_w_i    = w;
        csr_addr_i = addr;
        csr_data_i = data;
        @(negedge clk_i);
        csr_v_i = 1'b0;
        check_val("csr_resp_v", {63'd0, csr_resp_v_o}, 64'd1);
        rdata = csr_resp_data_o;
        csr_resp_yumi_i = 1'b1;
        @(negedge clk_i);
        csr_resp_yumi_i = 1'b0;
    endtask

    task automatic csr_wr(input logic [7:0] addr, input logic [63:0] data);
        logic [63:0] dummy;
        csr_op(1'b1, addr, data, dummy);
    endtask

    task automatic csr_rd(input logic [7:0] addr, output logic [63:0] data);
        csr_op(1'b0, addr, 64'd0, data);
    endtask

    task automatic wait_idle(input string tag);
        logic [63:0] b;
        b = 64'd1;
        for (int i = 0; i < 400; i++) begin
            csr_rd(8'h18, b);
            if (b == 64'd0) break;
        end
        check_val(tag, b, 64'd0);
    endtask

    task automatic setup_job(input logic [63:0] a, input logic [63:0] b, input logic [63:0] r,
                             input logic [63:0] len, input logic [63:0] op);
        csr_wr(8'h00, a);
        csr_wr(8'h08, b);
        csr_wr(8'h28, r);
        csr_wr(8'h10, len);
        csr_wr(8'h30, op);
    endtask

    logic [63:0] rd;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n_i       = 1'b0;
        csr_v_i         = 1'b0;
        csr_w_i         = 1'b0;
        csr_addr_i      = '0;
        csr_data_i      = '0;
        csr_resp_yumi_i = 1'b0;
        repeat (3) @(negedge clk_i);

        // Reset state
        check_val("rst_csr_ready", {63'd0, csr_ready_o}, 64'd1);
        check_val("rst_req_v", {63'd0, mem_req_v_o}, 64'd0);
        check_val("rst_resp_v", {63'd0, csr_resp_v_o}, 64'd0);
        check_val("rst_irq", {63'd0, irq_o}, 64'd0);
        reset_n_i = 1'b1;
        csr_rd(8'h20, rd); check_val("rst_status", rd, 64'd0);
        csr_rd(8'h38, rd); check_val("rst_result", rd, 64'd0);
        csr_rd(8'h50, rd); check_val("unmapped_rd", rd, 64'd0);

        // Memory images
        for (int i = 0; i < 8; i++) begin
            set_elem(40'h1000, i, 32'(i + 1));
            set_elem(40'h2000, i, 32'd1);
            set_elem(40'h8000, i, 32'(8 - i));
        end
        for (int i = 0; i < 24; i++) begin
            set_elem(40'h4000, i, (i < 20) ? 32'(i) : 32'd1000);
            set_elem(40'h5000, i, 32'd2);
        end
        set_elem(40'h7000, 0, 32'd5);
        set_elem(40'h7000, 1, 32'hFFFF_FFFD);
        set_elem(40'h7000, 2, 32'd0);
        set_elem(40'h7000, 3, 32'd7);
        set_elem(40'h7100, 0, 32'd2);
        set_elem(40'h7100, 1, 32'd4);
        set_elem(40'h7100, 2, 32'd0);
        set_elem(40'h7100, 3, 32'd7);

        // T1: single full chunk dot product, 1..8 . 1 = 36
        csr_wr(8'h40, 64'd1);
        setup_job(64'h1000, 64'h2000, 64'h3000, 64'd8, 64'd0);
        clear_stats();
        csr_wr(8'h18, 64'd1);
        wait_idle("t1_timeout");
        check_val("t1_loads", 64'(ld_count), 64'd16);
        check_val("t1_stores", 64'(st_count), 64'd1);
        check_val("t1_st_addr", 64'(st_addr), 64'h3000);
        check_val("t1_st_data", st_data, 64'd36);
        csr_rd(8'h38, rd); check_val("t1_result", rd, 64'd36);
        csr_rd(8'h20, rd); check_val("t1_status", rd, 64'd1);
        check_val("t1_irq", {63'd0, irq_o}, 64'd1);
        csr_wr(8'h20, 64'd1);
        csr_rd(8'h20, rd); check_val("t1_w1c", rd, 64'd0);
        check_val("t1_irq_clr", {63'd0, irq_o}, 64'd0);

        // T2: len 20 in chunks 8/8/4, sum(i*2, i<20) = 380
        setup_job(64'h4000, 64'h5000, 64'h6000, 64'd20, 64'd0);
        clear_stats();
        csr_wr(8'h18, 64'd1);
        wait_idle("t2_timeout");
        check_val("t2_loads", 64'(ld_count), 64'd40);
        check_val("t2_st_data", st_data, 64'd380);
        csr_rd(8'h38, rd); check_val("t2_result", rd, 64'd380);
        csr_wr(8'h20, 64'd3);

        // T3: L1 with a negative element: 3+7+0+0 = 10
        setup_job(64'h7000, 64'h7100, 64'h7200, 64'd4, 64'd1);
        clear_stats();
        csr_wr(8'h18, 64'd1);
        wait_idle("t3_timeout");
        check_val("t3_loads", 64'(ld_count), 64'd8);
        check_val("t3_st_addr", 64'(st_addr), 64'h7200);
        csr_rd(8'h38, rd); check_val("t3_result", rd, 64'd10);
        csr_wr(8'h20, 64'd3);
        csr_wr(8'h30, 64'd0);

        // T4: invalid lengths raise done+error with no memory traffic
        clear_stats();
        csr_wr(8'h10, 64'd0);
        csr_wr(8'h18, 64'd1);
        csr_rd(8'h18, rd); check_val("t4_len0_busy", rd, 64'd0);
        csr_rd(8'h20, rd); check_val("t4_len0_status", rd, 64'd3);
        check_val("t4_len0_irq", {63'd0, irq_o}, 64'd1);
        csr_wr(8'h20, 64'd3);
        csr_rd(8'h20, rd); check_val("t4_len0_w1c", rd, 64'd0);
        check_val("t4_len0_irq_clr", {63'd0, irq_o}, 64'd0);
        csr_wr(8'h10, 64'(MAX_LEN + 1));
        csr_wr(8'h18, 64'd1);
        csr_rd(8'h20, rd); check_val("t4_long_status", rd, 64'd3);
        check_val("t4_req_cycles", 64'(req_v_cycles), 64'd0);
        csr_rd(8'h38, rd); check_val("t4_result_kept", rd, 64'd10);
        csr_wr(8'h20, 64'd3);

        // T5: writes while busy are dropped; 10-cycle ready stall in REQ_A
        setup_job(64'h1000, 64'h8000, 64'h8100, 64'd8, 64'd0);
        clear_stats();
        stall_at   = 3;
        stall_left = 10;
        stall_seen = 1'b0;
        stall_bad  = 0;
        csr_wr(8'h18, 64'd1);
        csr_wr(8'h00, 64'h9000);
        csr_wr(8'h18, 64'd1);
        wait_idle("t5_timeout");
        stall_at = -1;
        csr_rd(8'h00, rd); check_val("t5_a_ptr_kept", rd, 64'h1000);
        check_val("t5_loads", 64'(ld_count), 64'd16);
        check_val("t5_stores", 64'(st_count), 64'd1);
        check_val("t5_stall_used", 64'(stall_left), 64'd0);
        check_val("t5_stall_stable", 64'(stall_bad), 64'd0);
        csr_rd(8'h38, rd); check_val("t5_result", rd, 64'd120);
        csr_wr(8'h20, 64'd3);

        // T6: asynchronous reset while waiting in DRAIN
        setup_job(64'h1000, 64'h2000, 64'h3000, 64'd8, 64'd0);
        clear_stats();
        resp_hold = 1'b1;
        csr_wr(8'h18, 64'd1);
        for (int i = 0; i < 100; i++) begin
            if (ld_count >= 16) break;
            @(negedge clk_i);
        end
        check_val("t6_loads_before_rst", 64'(ld_count), 64'd16);
        repeat (3) @(negedge clk_i);
        #2;
        reset_n_i = 1'b0;
        #1;
        check_val("t6_rst_req_v", {63'd0, mem_req_v_o}, 64'd0);
        check_val("t6_rst_req_w", {63'd0, mem_req_w_o}, 64'd0);
        check_val("t6_rst_addr", 64'(mem_req_addr_o), 64'd0);
        check_val("t6_rst_csr_ready", {63'd0, csr_ready_o}, 64'd1);
        check_val("t6_rst_irq", {63'd0, irq_o}, 64'd0);
        resp_q.delete();
        resp_hold = 1'b0;
        repeat (2) @(negedge clk_i);
        reset_n_i = 1'b1;
        csr_rd(8'h00, rd); check_val("t6_a_ptr_rst", rd, 64'd0);
        csr_rd(8'h38, rd); check_val("t6_result_rst", rd, 64'd0);
        setup_job(64'h1000, 64'h2000, 64'h3000, 64'd8, 64'd0);
        clear_stats();
        csr_wr(8'h18, 64'd1);
        wait_idle("t6_timeout");
        check_val("t6_loads", 64'(ld_count), 64'd16);
        check_val("t6_st_data", st_data, 64'd36);
        csr_rd(8'h38, rd); check_val("t6_result", rd, 64'd36);
        csr_rd(8'h20, rd); check_val("t6_status", rd, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
